// File: rtl/lifo_stack_v2.sv
// Parametrised synchronous LIFO with occupancy count, almost-full threshold, top-of-stack peek,
// push+pop replace-top / empty bypass, flush and sticky overflow/underflow flags.
module lifo_stack_v2 #(
    parameter int STACK_DEPTH = 8,
    parameter int WORD_LEN    = 8,
    parameter int AF_LEVEL    = 6
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [WORD_LEN-1:0]            data_in,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           flush,
    input  logic                           clear_err,
    output logic [WORD_LEN-1:0]            data_out,
    output logic                           out_valid,
    output logic [WORD_LEN-1:0]            top,
    output logic [$clog2(STACK_DEPTH):0]   count,
    output logic                           full,
    output logic                           empty,
    output logic                           almost_full,
    output logic                           overflow,
    output logic                           underflow
);

    localparam int CW = $clog2(STACK_DEPTH) + 1;
    localparam int AW = $clog2(STACK_DEPTH);

    logic [WORD_LEN-1:0] mem [STACK_DEPTH];

    logic [CW-1:0]       count_reg, count_next;
    logic [WORD_LEN-1:0] data_out_reg, data_out_next;
    logic                out_valid_reg, out_valid_next;
    logic                overflow_reg, overflow_next;
    logic                underflow_reg, underflow_next;

    logic                mem_we;
    logic [AW-1:0]       mem_waddr;
    logic [CW-1:0]       count_m1;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       top_ptr;
    logic                is_full;
    logic                is_empty;

    // wr_ptr is only used when not full and top_ptr only when not empty, so truncation is safe.
    assign count_m1 = count_reg - CW'(1);
    assign wr_ptr   = count_reg[AW-1:0];
    assign top_ptr  = count_m1[AW-1:0];
    assign is_full  = (count_reg == CW'(STACK_DEPTH));
    assign is_empty = (count_reg == '0);

    always_comb begin
        count_next     = count_reg;
        data_out_next  = data_out_reg;
        out_valid_next = 1'b0;
        overflow_next  = overflow_reg  & ~clear_err;
        underflow_next = underflow_reg & ~clear_err;
        mem_we         = 1'b0;
        mem_waddr      = wr_ptr;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (is_full) begin
                        overflow_next = 1'b1;
                    end else begin
                        mem_we     = 1'b1;
                        count_next = count_reg + CW'(1);
                    end
                end
                2'b01: begin
                    if (is_empty) begin
                        underflow_next = 1'b1;
                    end else begin
                        data_out_next  = mem[top_ptr];
                        out_valid_next = 1'b1;
                        count_next     = count_m1;
                    end
                end
                2'b11: begin
                    out_valid_next = 1'b1;
                    if (is_empty) begin
                        data_out_next = data_in;
                    end else begin
                        // Replace-top: old top leaves, new word takes its slot.
                        data_out_next = mem[top_ptr];
                        mem_we        = 1'b1;
                        mem_waddr     = top_ptr;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            count_reg     <= '0;
            data_out_reg  <= '0;
            out_valid_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            count_reg     <= count_next;
            data_out_reg  <= data_out_next;
            out_valid_reg <= out_valid_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // Storage is left uninitialised by reset; only the write is blocked during it.
    always_ff @(posedge clk) begin
        if (mem_we && !rstn) begin
            mem[mem_waddr] <= data_in;
        end
    end

    assign data_out    = data_out_reg;
    assign out_valid   = out_valid_reg;
    assign count       = count_reg;
    assign full        = is_full;
    assign empty       = is_empty;
    assign almost_full = (count_reg >= CW'(AF_LEVEL));
    assign top         = is_empty ? '0 : mem[top_ptr];
    assign overflow    = overflow_reg;
    assign underflow   = underflow_reg;

endmodule

// File: tb/tb_lifo_stack_v2.sv
// Directed and randomized checking of lifo_stack_v2 against a queue-based stack model.
module tb_lifo_stack_v2;

    localparam int D  = 8;
    localparam int W  = 8;
    localparam int AF = 6;

    logic         clk = 1'b0;
    logic         rstn = 1'b1;
    logic [W-1:0] data_in = '0;
    logic         push = 1'b0;
    logic         pop = 1'b0;
    logic         flush = 1'b0;
    logic         clear_err = 1'b0;
    logic [W-1:0] data_out;
    logic         out_valid;
    logic [W-1:0] top;
    logic [3:0]   count;
    logic         full;
    logic         empty;
    logic         almost_full;
    logic         overflow;
    logic         underflow;

    lifo_stack_v2 #(.STACK_DEPTH(D), .WORD_LEN(W), .AF_LEVEL(AF)) dut (
        .clk(clk), .rstn(rstn), .data_in(data_in), .push(push), .pop(pop),
        .flush(flush), .clear_err(clear_err), .data_out(data_out), .out_valid(out_valid),
        .top(top), .count(count), .full(full), .empty(empty), .almost_full(almost_full),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the stack is a queue whose back is the top.
    logic [W-1:0] q[$];
    logic [W-1:0] m_dout = '0;
    logic         m_valid = 1'b0;
    logic         m_ovf = 1'b0;
    logic         m_unf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic pu, input logic po,
                              input logic fl, input logic ce, input logic [W-1:0] din);
        if (r) begin
            q.delete();
            m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
            return;
        end
        m_valid = 1'b0;
        if (ce) begin
            m_ovf = 1'b0; m_unf = 1'b0;
        end
        if (fl) begin
            q.delete();
        end else if (pu && po) begin
            m_valid = 1'b1;
            if (q.size() == 0) begin
                m_dout = din;
            end else begin
                m_dout = q.pop_back();
                q.push_back(din);
            end
        end else if (pu) begin
            if (q.size() == D) m_ovf = 1'b1;
            else q.push_back(din);
        end else if (po) begin
            if (q.size() == 0) m_unf = 1'b1;
            else begin
                m_dout  = q.pop_back();
                m_valid = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        logic [W-1:0] exp_top;
        exp_top = (q.size() == 0) ? '0 : q[q.size()-1];
        chk("count", 32'(count), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(q.size() == D));
        chk("almost_full", 32'(almost_full), 32'(q.size() >= AF));
        chk("top", 32'(top), 32'(exp_top));
        chk("data_out", 32'(data_out), 32'(m_dout));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
    endtask

    task automatic cycle(input logic r, input logic pu, input logic po,
                         input logic fl, input logic ce, input logic [W-1:0] din);
        @(negedge clk);
        rstn = r; push = pu; pop = po; flush = fl; clear_err = ce; data_in = din;
        @(posedge clk);
        model_step(r, pu, po, fl, ce, din);
        #1;
        $display("t=%0t rst=%0b push=%0b pop=%0b flush=%0b clr=%0b din=%02h | cnt=%0d top=%02h dout=%02h v=%0b ovf=%0b unf=%0b",
                 $time, r, pu, po, fl, ce, din, count, top, data_out, out_valid, overflow, underflow);
        check_all();
    endtask

    initial begin
        // Reset, then reset mid-operation with count=3 and push/pop asserted.
        cycle(1, 0, 0, 0, 0, 8'h00);
        cycle(1, 0, 0, 0, 0, 8'h00);
        for (int i = 1; i <= 3; i++) cycle(0, 1, 0, 0, 0, 8'(i));
        cycle(1, 1, 1, 0, 0, 8'h55);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);

        // Fill/drain with overflow and underflow.
        for (int i = 1; i <= 8; i++) begin
            cycle(0, 1, 0, 0, 0, 8'(i));
            chk("fill_af", 32'(almost_full), 32'(i >= 6));
        end
        chk("fill_full", 32'(full), 32'd1);
        cycle(0, 1, 0, 0, 0, 8'hAA);
        chk("ovf_set", 32'(overflow), 32'd1);
        for (int i = 8; i >= 1; i--) begin
            cycle(0, 0, 1, 0, 0, 8'h00);
            chk("drain_val", 32'(data_out), 32'(i));
        end
        cycle(0, 0, 1, 0, 0, 8'h00);
        chk("unf_set", 32'(underflow), 32'd1);
        cycle(0, 0, 0, 0, 1, 8'h00);

        // Replace-top.
        cycle(0, 1, 0, 0, 0, 8'd5);
        cycle(0, 1, 0, 0, 0, 8'd6);
        cycle(0, 1, 1, 0, 0, 8'd9);
        chk("rep_dout", 32'(data_out), 32'd6);
        chk("rep_top", 32'(top), 32'd9);
        chk("rep_count", 32'(count), 32'd2);
        cycle(0, 0, 1, 0, 0, 8'h00);
        chk("rep_pop", 32'(data_out), 32'd9);
        cycle(0, 0, 1, 0, 0, 8'h00);

        // Bypass on empty, then replace while full.
        cycle(0, 1, 1, 0, 0, 8'h3C);
        chk("byp_dout", 32'(data_out), 32'h3C);
        chk("byp_unf", 32'(underflow), 32'd0);
        for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0, 0, 8'(8'h40 + i));
        cycle(0, 1, 1, 0, 0, 8'hE1);
        chk("fullrep_ovf", 32'(overflow), 32'd0);
        chk("fullrep_dout", 32'(data_out), 32'h47);

        // Flush with count=4 and pop in the same cycle.
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 0, 8'h00);
        cycle(0, 0, 1, 1, 0, 8'h00);
        chk("flush_valid", 32'(out_valid), 32'd0);
        cycle(0, 1, 0, 0, 0, 8'd7);
        chk("flush_top", 32'(top), 32'd7);

        // Error clear, and clear_err racing a new overflow.
        for (int i = 0; i < 7; i++) cycle(0, 1, 0, 0, 0, 8'(8'h70 + i));
        cycle(0, 1, 0, 0, 0, 8'hBB);
        cycle(0, 0, 0, 0, 1, 8'h00);
        chk("clr_ovf", 32'(overflow), 32'd0);
        cycle(0, 1, 0, 0, 1, 8'hCC);
        chk("clr_race_ovf", 32'(overflow), 32'd1);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            cycle(r == 0, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
                  r >= 97, $urandom_range(0, 99) < 6, 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
